// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer between IF and ID.
// Pairs each issued fetch PC with the instruction word the synchronous SRAM
// returns one cycle later, queues the {pc, inst} pairs in a small FIFO, and
// presents the head to ID. A branch flush discards everything buffered or in
// flight.
module inst_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] if_to_id_bus,
    input  logic        if_stall,
    input  logic [31:0] inst_sram_rdata,
    input  logic        flush,
    input  logic        id_stall,
    output logic [64:0] fb_to_id_bus,
    output logic        stallreq_fb,
    output logic        overflow
);

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W+2)'(DEPTH);

    // Storage (data only, never reset)
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [31:0]      r_mem_inst [DEPTH];

    // Control state
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_pend_valid;
    logic [31:0]      r_pend_pc;
    logic             r_overflow;

    logic             w_ce;
    logic [31:0]      w_pc;
    logic             w_cap;
    logic             w_count_nz;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_push_req;
    logic             w_ovf_evt;
    logic             w_push;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_inst;
    logic [PTR_W+1:0] w_occ;

    assign w_ce = if_to_id_bus[32];
    assign w_pc = if_to_id_bus[31:0];

    // A request is captured only while IF is advancing, so a request held by
    // a frozen IF was already captured in the cycle before the freeze.
    assign w_cap = w_ce & ~if_stall & ~flush;

    assign w_count_nz = (r_count != '0);
    assign w_full     = (r_count == DEPTH_CNT);
    assign w_valid    = w_count_nz & ~flush;
    assign w_pop      = w_valid & ~id_stall;

    // A push into a full FIFO with no pop is dropped and flagged; the stall
    // request below keeps this from happening under a well-behaved CTRL.
    assign w_push_req = r_pend_valid & ~flush;
    assign w_ovf_evt  = w_push_req & w_full & ~w_pop;
    assign w_push     = w_push_req & ~w_ovf_evt;

    assign w_head_pc   = w_count_nz ? r_mem_pc[r_rd_ptr]   : 32'd0;
    assign w_head_inst = w_count_nz ? r_mem_inst[r_rd_ptr] : 32'd0;

    assign fb_to_id_bus = {w_valid, w_head_pc, w_head_inst};

    // Counting the in-flight request reserves a slot for it before it lands.
    assign w_occ       = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_pend_valid};
    assign stallreq_fb = (w_occ >= DEPTH_OCC);
    assign overflow    = r_overflow;

    // Control state: pointers, occupancy, pending request and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_overflow   <= 1'b0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_pend_valid <= w_cap;
            if (w_cap) begin
                r_pend_pc <= w_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO write: pending pc joined with the SRAM word returned this cycle
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_pend_pc;
            r_mem_inst[r_wr_ptr] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus a
// randomized stretch, all compared against a queue-based reference model.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        if_stall;
    logic [31:0] rdata;
    logic        flush;
    logic        id_stall;
    logic [64:0] fb_to_id_bus;
    logic        stallreq_fb;
    logic        overflow;
    logic [32:0] if_to_id_bus;

    assign if_to_id_bus = {ce, pc};

    inst_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_to_id_bus    (if_to_id_bus),
        .if_stall        (if_stall),
        .inst_sram_rdata (rdata),
        .flush           (flush),
        .id_stall        (id_stall),
        .fb_to_id_bus    (fb_to_id_bus),
        .stallreq_fb     (stallreq_fb),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of {pc, inst}, one pending request, sticky error
    logic [63:0] mq[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'd0;
    bit          m_ovf = 1'b0;

    function automatic bit m_stall();
        return (mq.size() + int'(m_pend)) >= DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge and compare every output with the model
    task automatic samp();
        logic        e_valid;
        logic [63:0] e_head;
        @(negedge clk);
        e_valid = (mq.size() != 0) && !flush;
        e_head  = (mq.size() != 0) ? mq[0] : 64'd0;
        chk("valid",    64'(fb_to_id_bus[64]), 64'(e_valid));
        chk("head",     fb_to_id_bus[63:0],    e_head);
        chk("stallreq", 64'(stallreq_fb),      64'(m_stall()));
        chk("overflow", 64'(overflow),         64'(m_ovf));
    endtask

    // Advance the model with this cycle's inputs, then cross the clock edge
    task automatic adv();
        bit pop;
        bit full_nopop;
        if (rst) begin
            mq.delete();
            m_pend    = 1'b0;
            m_pend_pc = 32'd0;
            m_ovf     = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_pend = 1'b0;
        end else begin
            pop        = (mq.size() != 0) && !id_stall;
            full_nopop = (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (m_pend) begin
                if (full_nopop) m_ovf = 1'b1;
                else            mq.push_back({m_pend_pc, rdata});
            end
            m_pend = ce && !if_stall;
            if (m_pend) m_pend_pc = pc;
        end
        @(posedge clk);
        #1;
        rdata = $urandom;
    endtask

    task automatic cyc();
        samp();
        adv();
    endtask

    task automatic drain();
        ce = 1'b0; if_stall = 1'b0; id_stall = 1'b0; flush = 1'b0;
        repeat (DEPTH + 3) cyc();
    endtask

    int nval;

    initial begin
        rst = 1'b1; ce = 1'b1; pc = 32'h1000; if_stall = 1'b0;
        rdata = 32'h0; flush = 1'b0; id_stall = 1'b0;

        // Reset held two cycles with ce asserted
        repeat (2) begin
            samp();
            chk("rst_valid",    64'(fb_to_id_bus[64]), 64'd0);
            chk("rst_stallreq", 64'(stallreq_fb),      64'd0);
            chk("rst_overflow", 64'(overflow),         64'd0);
            adv();
        end
        rst = 1'b0; ce = 1'b0;
        cyc();
        samp();
        chk("rst_nocap", 64'(fb_to_id_bus[64]), 64'd0);
        adv();

        // Single fetch: visible exactly once, two cycles after ce
        ce = 1'b1; pc = 32'hbfc00000; id_stall = 1'b0;
        cyc();
        ce = 1'b0; rdata = 32'h24020001;
        cyc();
        samp();
        chk("single_valid", 64'(fb_to_id_bus[64]), 64'd1);
        chk("single_bus",   fb_to_id_bus[63:0],    64'hbfc00000_24020001);
        adv();
        samp();
        chk("single_once", 64'(fb_to_id_bus[64]), 64'd0);
        adv();

        // Fill with ID stalled and IF gated by the stall request
        id_stall = 1'b1; pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            ce = 1'b1;
            if_stall = m_stall();
            samp();
            adv();
            if (!if_stall) pc = pc + 32'd4;
        end
        samp();
        chk("fill_stallreq", 64'(stallreq_fb), 64'd1);
        chk("fill_overflow", 64'(overflow),    64'd0);
        adv();
        ce = 1'b0; if_stall = 1'b0; id_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("drain_valid", 64'(fb_to_id_bus[64]),    64'd1);
            chk("drain_pc",    64'(fb_to_id_bus[63:32]), 64'(i * 4));
            adv();
        end
        samp();
        chk("drain_empty", 64'(fb_to_id_bus[64]), 64'd0);
        adv();

        // Held request across a frozen IF is queued once
        ce = 1'b1; pc = 32'h40; if_stall = 1'b0; id_stall = 1'b1;
        cyc();
        if_stall = 1'b1;
        repeat (3) cyc();
        ce = 1'b0; if_stall = 1'b0; id_stall = 1'b0;
        nval = 0;
        repeat (6) begin
            samp();
            if (fb_to_id_bus[64]) begin
                nval++;
                chk("held_pc", 64'(fb_to_id_bus[63:32]), 64'h40);
            end
            adv();
        end
        chk("held_count", 64'(nval), 64'd1);

        // Flush with three entries queued and one pending
        id_stall = 1'b1; if_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; pc = 32'h100 + 32'(i * 4);
            cyc();
        end
        flush = 1'b1; ce = 1'b1; pc = 32'h200;
        samp();
        chk("flush_valid", 64'(fb_to_id_bus[64]), 64'd0);
        adv();
        flush = 1'b0; ce = 1'b1; pc = 32'h80;
        samp();
        chk("postflush_valid", 64'(fb_to_id_bus[64]), 64'd0);
        chk("postflush_stall", 64'(stallreq_fb),      64'd0);
        adv();
        ce = 1'b0;
        samp();
        chk("target_t1", 64'(fb_to_id_bus[64]), 64'd0);
        adv();
        samp();
        chk("target_valid", 64'(fb_to_id_bus[64]),    64'd1);
        chk("target_pc",    64'(fb_to_id_bus[63:32]), 64'h80);
        adv();
        drain();

        // Full with a pending push and a simultaneous pop
        id_stall = 1'b1; if_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ce = 1'b1; pc = 32'h300 + 32'(i * 4);
            cyc();
        end
        ce = 1'b0; id_stall = 1'b0;
        samp();
        chk("fullpp_head", 64'(fb_to_id_bus[63:32]), 64'h300);
        adv();
        id_stall = 1'b1;
        samp();
        chk("fullpp_next",     64'(fb_to_id_bus[63:32]), 64'h304);
        chk("fullpp_stallreq", 64'(stallreq_fb),         64'd1);
        chk("fullpp_overflow", 64'(overflow),            64'd0);
        adv();
        drain();

        // Randomized traffic with CTRL gating IF from the stall request
        for (int i = 0; i < 400; i++) begin
            ce       = 1'($urandom_range(0, 3) != 0);
            pc       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            if_stall = m_stall() || ($urandom_range(0, 5) == 0);
            id_stall = 1'($urandom_range(0, 2) == 0);
            flush    = 1'($urandom_range(0, 19) == 0);
            cyc();
        end
        drain();

        // Ungated IF overruns a stalled buffer and sets the sticky flag
        id_stall = 1'b1; if_stall = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ce = 1'b1; pc = 32'h500 + 32'(i * 4);
            cyc();
        end
        ce = 1'b0;
        samp();
        chk("ovf_set", 64'(overflow), 64'd1);
        adv();
        drain();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        samp();
        chk("ovf_clear", 64'(overflow), 64'd0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Decoupling buffer between the IF stage and the ID stage of the 5-stage MIPS pipeline. It pairs each fetched PC with the instruction word that the synchronous inst SRAM returns one cycle later, and queues the {pc, inst} pairs in a small FIFO. It feeds ID through a valid/pc/inst bus and raises a stall request toward CTRL when full. A branch flush empties it.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2
PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
if_to_id_bus  in  33  {ce[32], pc[31:0]} from IF; ce=1 means an SRAM read was issued for pc this cycle
if_stall  in  1  stall[0] from CTRL; IF is frozen this cycle, so a held request is not new
inst_sram_rdata  in  32  instruction word for the request issued in the previous cycle
flush  in  1  branch taken (br_e); discard every buffered or in-flight instruction
id_stall  in  1  ID cannot accept this cycle
fb_to_id_bus  out  65  {valid[64], pc[63:32], inst[31:0]} to ID
stallreq_fb  out  1  buffer cannot take more; CTRL must stall IF
overflow  out  1  sticky error flag, for verification only

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr, rd_ptr, count, pend_valid, pend_pc and overflow all clear to 0.
  - Outputs after reset: valid=0, pc=0, inst=0, stallreq_fb=0, overflow=0.
  - rst has priority over flush and every other input.
- Capture (cycle t):
  - cap = ce & !if_stall & !flush.
  - On posedge: pend_valid <= cap, and pend_pc <= pc when cap=1.
  - A request held by a frozen IF (ce stays 1, pc unchanged) is captured exactly once.
- Push (cycle t+1):
  - If pend_valid=1 and flush=0: write {pend_pc, inst_sram_rdata} at wr_ptr, and wr_ptr <= wr_ptr+1 (mod DEPTH).
  - inst_sram_rdata is sampled only in this cycle.
- Output:
  - valid = (count != 0) & !flush.
  - pc and inst are taken from the head entry when count != 0, and are 0 otherwise.
  - The head is combinational from registers.
  - Minimum latency: ce at cycle t, then pushed at the end of t+1, then visible on fb_to_id_bus in t+2.
- Pop:
  - pop = valid & !id_stall.
  - rd_ptr <= rd_ptr+1 (mod DEPTH).
- Count:
  - count <= count + push - pop.
  - Push and pop in the same cycle are legal at any occupancy, including full, and leave count unchanged.
- Stall request:
  - stallreq_fb = (count + pend_valid) >= DEPTH.
  - Driven from registers only; no combinational path from id_stall, if_stall or flush.
  - This guarantees that an in-flight pend always has a free slot.
- Flush (synchronous, takes effect at posedge):
  - count, wr_ptr, rd_ptr and pend_valid all clear to 0.
  - No push, pop or capture happens in the flush cycle; valid=0 during it.
  - The next capture is the branch target, issued by IF in the following cycle.
  - Delay-slot preservation is handled upstream: flush is asserted only when every queued or in-flight instruction is to be discarded.
- Overflow:
  - Set when a push occurs with count==DEPTH and no pop.
  - That write is dropped. The flag clears only on rst.
- Width rules:
  - Pointers wrap naturally at PTR_W bits.
  - count is PTR_W+1 bits and ranges 0..DEPTH.

Test Plan:
- Reset: hold rst 2 cycles with ce=1 → valid=0, stallreq_fb=0, overflow=0; the first capture happens only after rst drops.
- Single fetch: ce=1, pc=0xbfc00000 at t; rdata=0x24020001 at t+1; id_stall=0 → at t+2 bus = {1, 0xbfc00000, 0x24020001}, valid for exactly 1 cycle.
- Fill:
  - Stimulus: stream pc 0x...00, 04, 08, ... with id_stall=1.
  - Required: stallreq_fb=1 once count+pend reaches 4; with CTRL gating if_stall, exactly 4 entries are held and overflow stays 0.
  - Then release id_stall: pcs drain in order 00, 04, 08, 0C, one per cycle.
- Held request: if_stall=1 for 3 cycles with ce=1, pc=0x40 → exactly one entry for pc 0x40 is queued.
- Flush: 3 entries queued plus 1 pending, flush pulse → next cycle valid=0, count=0; target pc 0x80 appears 2 cycles after its ce.
- Full with simultaneous push/pop: count=4, pend_valid=1, id_stall=0 → head pops, new entry written, count stays 4, overflow=0.
